// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan driver.
//   scan_state_t : scan FSM states (SHOW a digit, GHOST all-off gap)
//   SEG_OFF      : active-low segment word with every segment dark
//   HEX_SEG      : nibble -> active-high gfedcba pattern, entry 0 in the low slice
package seg7_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    GHOST = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational hex nibble to 7-segment pattern.
//   nibble  in  4  hex value 0..F
//   pattern out 7  active-high segments, a..g = [0]..[6]
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode 7-segment scanner.
//   clk, rst_n         clock, asynchronous active-low reset
//   en_scan            scan tick pulse; all display outputs move only on it
//   load               capture digits_in/dp_in/blink_in into the shadow buffer
//   digits_in          one hex nibble per digit, [3:0] = rightmost digit
//   dp_in, blink_in    per-digit decimal point and blink enable
//   lz_blank           level, blank leading zeros (digit 0 always shown)
//   an_n, seg_n, dp_n  active-low anode / segment / decimal point drive
//   frame_done         one-cycle pulse on the tick that restarts the scan at digit 0
// The shadow buffer is copied to the active buffer only at a frame wrap, so a
// frame never mixes old and new digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int GHOST_TICKS = 1,
  parameter int BLINK_DIV   = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_scan,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blink_in,
  input  logic                      lz_blank,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic [6:0]                seg_n,
  output logic                      dp_n,
  output logic                      frame_done
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [3:0]         GHOST_LAST = (GHOST_TICKS == 0) ? 4'd0 : 4'(GHOST_TICKS - 1);

  scan_state_t state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [3:0]         ghost_cnt_reg, ghost_cnt_next;
  logic               primed_reg, primed_next;
  logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;
  logic               blink_phase_reg, blink_phase_next;
  logic               wrap;

  logic [4*NUM_DIGITS-1:0] shadow_digits_reg, active_digits_reg, active_digits_next;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg, active_dp_reg, active_dp_next;
  logic [NUM_DIGITS-1:0]   shadow_blink_reg, active_blink_reg, active_blink_next;
  logic                    pending_reg, pending_next;

  logic [NUM_DIGITS-1:0] an_n_reg, an_n_next;
  logic [6:0]            seg_n_reg, seg_n_next;
  logic                  dp_n_reg, dp_n_next;
  logic                  frame_done_reg, frame_done_next;

  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blink, cur_lz, digit_blank;
  logic [6:0]          seg_pattern;
  logic [NUM_DIGITS:0] lz_run;
  logic [NUM_DIGITS-1:0] lz_mask;

  // Scan FSM. primed_reg distinguishes the post-reset GHOST, whose expiry
  // starts at digit 0 rather than advancing from idx 0.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    ghost_cnt_next = ghost_cnt_reg;
    primed_next    = primed_reg;
    wrap           = 1'b0;
    if (en_scan) begin
      if (state_reg == SHOW && GHOST_TICKS > 0) begin
        state_next     = GHOST;
        ghost_cnt_next = 4'd0;
      end else if (state_reg == GHOST && ghost_cnt_reg != GHOST_LAST) begin
        ghost_cnt_next = ghost_cnt_reg + 4'd1;
      end else begin
        state_next  = SHOW;
        primed_next = 1'b1;
        if (!primed_reg || idx_reg == IDX_LAST) begin
          idx_next = '0;
          wrap     = 1'b1;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
    end
  end

  // Active buffer update. A load coinciding with a wrap bypasses the shadow.
  always_comb begin
    active_digits_next = active_digits_reg;
    active_dp_next     = active_dp_reg;
    active_blink_next  = active_blink_reg;
    pending_next       = pending_reg;
    if (wrap && load) begin
      active_digits_next = digits_in;
      active_dp_next     = dp_in;
      active_blink_next  = blink_in;
      pending_next       = 1'b0;
    end else if (wrap && pending_reg) begin
      active_digits_next = shadow_digits_reg;
      active_dp_next     = shadow_dp_reg;
      active_blink_next  = shadow_blink_reg;
      pending_next       = 1'b0;
    end else if (load) begin
      pending_next = 1'b1;
    end
  end

  always_comb begin
    blink_cnt_next   = blink_cnt_reg;
    blink_phase_next = blink_phase_reg;
    if (en_scan) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_next   = '0;
        blink_phase_next = ~blink_phase_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 1'b1;
      end
    end
  end

  // lz_run[k] is 1 when digit k and every digit above it are zero.
  assign lz_run[NUM_DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      assign lz_run[gi] = lz_run[gi+1] & (active_digits_next[gi*4 +: 4] == 4'd0);
    end
  endgenerate
  assign lz_mask = {lz_run[NUM_DIGITS-1:1], 1'b0};

  always_comb begin
    cur_nib   = 4'd0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        cur_nib   = active_digits_next[i*4 +: 4];
        cur_dp    = active_dp_next[i];
        cur_blink = active_blink_next[i];
        cur_lz    = lz_mask[i];
      end
    end
  end

  assign digit_blank = (lz_blank && cur_lz) || (blink_phase_reg && cur_blink);

  seg7_decoder u_decoder (
    .nibble  (cur_nib),
    .pattern (seg_pattern)
  );

  always_comb begin
    an_n_next       = an_n_reg;
    seg_n_next      = seg_n_reg;
    dp_n_next       = dp_n_reg;
    frame_done_next = 1'b0;
    if (en_scan) begin
      frame_done_next = wrap;
      if (state_next == SHOW && !digit_blank) begin
        an_n_next  = ~(NUM_DIGITS'(1) << idx_next);
        seg_n_next = ~seg_pattern;
        dp_n_next  = ~cur_dp;
      end else begin
        an_n_next  = '1;
        seg_n_next = SEG_OFF;
        dp_n_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= GHOST;
      idx_reg           <= '0;
      ghost_cnt_reg     <= 4'd0;
      primed_reg        <= 1'b0;
      blink_cnt_reg     <= '0;
      blink_phase_reg   <= 1'b0;
      shadow_digits_reg <= '0;
      shadow_dp_reg     <= '0;
      shadow_blink_reg  <= '0;
      active_digits_reg <= '0;
      active_dp_reg     <= '0;
      active_blink_reg  <= '0;
      pending_reg       <= 1'b0;
      an_n_reg          <= '1;
      seg_n_reg         <= SEG_OFF;
      dp_n_reg          <= 1'b1;
      frame_done_reg    <= 1'b0;
    end else begin
      state_reg         <= state_next;
      idx_reg           <= idx_next;
      ghost_cnt_reg     <= ghost_cnt_next;
      primed_reg        <= primed_next;
      blink_cnt_reg     <= blink_cnt_next;
      blink_phase_reg   <= blink_phase_next;
      if (load) begin
        shadow_digits_reg <= digits_in;
        shadow_dp_reg     <= dp_in;
        shadow_blink_reg  <= blink_in;
      end
      active_digits_reg <= active_digits_next;
      active_dp_reg     <= active_dp_next;
      active_blink_reg  <= active_blink_next;
      pending_reg       <= pending_next;
      an_n_reg          <= an_n_next;
      seg_n_reg         <= seg_n_next;
      dp_n_reg          <= dp_n_next;
      frame_done_reg    <= frame_done_next;
    end
  end

  assign an_n       = an_n_reg;
  assign seg_n      = seg_n_reg;
  assign dp_n       = dp_n_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed-vector bench for seg7_scan_driver.
//   u_dut   : default parameters (4 digits, 1 ghost tick, blink 256)
//   u_blink : 4 digits, no ghost ticks, BLINK_DIV=4, for the blink check
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_scan, load, lz_blank;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blink_in;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n, frame_done;

  logic        en_b, load_b;
  logic [3:0]  blink_b;
  logic [3:0]  an_n_b;
  logic [6:0]  seg_n_b;
  logic        dp_n_b, frame_done_b;

  int total = 0;
  int bad   = 0;

  // Expected per-digit drive for u_dut (blanked digits: an F, seg 7F, dp 1).
  logic [3:0] exp_an  [4];
  logic [6:0] exp_seg [4];
  logic       exp_dp  [4];

  always #5 clk = ~clk;

  seg7_scan_driver u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_scan    (en_scan),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blink_in   (blink_in),
    .lz_blank   (lz_blank),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .GHOST_TICKS(0), .BLINK_DIV(4)) u_blink (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_scan    (en_b),
    .load       (load_b),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blink_in   (blink_b),
    .lz_blank   (lz_blank),
    .an_n       (an_n_b),
    .seg_n      (seg_n_b),
    .dp_n       (dp_n_b),
    .frame_done (frame_done_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_load(input logic [15:0] data);
    @(negedge clk);
    digits_in = data;
    load      = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic tick(input bit ld, input logic [15:0] data);
    @(negedge clk);
    en_scan = 1'b1;
    if (ld) begin
      digits_in = data;
      load      = 1'b1;
    end
    @(posedge clk);
    #1;
    en_scan = 1'b0;
    load    = 1'b0;
  endtask

  // Even slots show digit slot/2, odd slots are the ghost gap; slot 0 is the wrap.
  task automatic tick_and_check(input int slot, input bit ld, input logic [15:0] data);
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    tick(ld, data);
    if (slot % 2 == 0) begin
      ea = exp_an[slot/2];
      es = exp_seg[slot/2];
      ed = exp_dp[slot/2];
    end else begin
      ea = 4'hF;
      es = 7'h7F;
      ed = 1'b1;
    end
    $display("tick slot=%0d an_n=%b seg_n=%h dp_n=%b frame_done=%b", slot, an_n, seg_n, dp_n, frame_done);
    check_eq($sformatf("s%0d_an", slot), 32'(an_n), 32'(ea));
    check_eq($sformatf("s%0d_seg", slot), 32'(seg_n), 32'(es));
    check_eq($sformatf("s%0d_dp", slot), 32'(dp_n), 32'(ed));
    check_eq($sformatf("s%0d_fd", slot), 32'(frame_done), 32'(slot == 0));
  endtask

  task automatic set_exp(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                         input logic [6:0] s0, input logic [3:0] dark, input logic [3:0] dps);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int d = 0; d < 4; d++) begin
      if (dark[d]) begin
        exp_an[d]  = 4'hF;
        exp_seg[d] = 7'h7F;
        exp_dp[d]  = 1'b1;
      end else begin
        exp_an[d]    = 4'hF;
        exp_an[d][d] = 1'b0;
        exp_seg[d]   = s[d];
        exp_dp[d]    = ~dps[d];
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en_scan = 1'b0; load = 1'b0; lz_blank = 1'b0;
    digits_in = 16'h0; dp_in = 4'h0; blink_in = 4'h0;
    en_b = 1'b0; load_b = 1'b0; blink_b = 4'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_an", 32'(an_n), 32'hF);
    check_eq("rst_seg", 32'(seg_n), 32'h7F);
    check_eq("rst_dp", 32'(dp_n), 32'h1);
    check_eq("rst_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic scan: 1234, dp on digit 1, two frames
    dp_in = 4'b0010;
    pulse_load(16'h1234);
    set_exp(7'h79, 7'h24, 7'h30, 7'h19, 4'b0000, 4'b0010);
    for (int t = 0; t < 16; t++) tick_and_check(t % 8, 1'b0, 16'h0);

    // Reset mid-SHOW: outputs dark without any clock edge
    tick_and_check(0, 1'b0, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_an", 32'(an_n), 32'hF);
    check_eq("rstmid_seg", 32'(seg_n), 32'h7F);
    check_eq("rstmid_dp", 32'(dp_n), 32'h1);
    for (int t = 0; t < 2; t++) begin
      tick(1'b0, 16'h0);
      check_eq("rsthold_fd", 32'(frame_done), 32'h0);
      check_eq("rsthold_an", 32'(an_n), 32'hF);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Leading-zero blanking: 0070
    dp_in = 4'b0000;
    lz_blank = 1'b1;
    pulse_load(16'h0070);
    set_exp(7'h40, 7'h40, 7'h78, 7'h40, 4'b1100, 4'b0000);
    for (int s = 0; s < 8; s++) tick_and_check(s, 1'b0, 16'h0);

    // Double buffering: two loads mid-frame, current frame unchanged
    lz_blank = 1'b0;
    set_exp(7'h40, 7'h40, 7'h78, 7'h40, 4'b0000, 4'b0000);
    for (int s = 0; s < 8; s++) begin
      tick_and_check(s, 1'b0, 16'h0);
      if (s == 2) pulse_load(16'h1111);
      if (s == 4) pulse_load(16'h2222);
    end
    set_exp(7'h24, 7'h24, 7'h24, 7'h24, 4'b0000, 4'b0000);
    for (int s = 0; s < 8; s++) tick_and_check(s, 1'b0, 16'h0);

    // Wrap bypass: load on the wrapping tick is shown in that same frame
    set_exp(7'h00, 7'h00, 7'h00, 7'h00, 4'b0000, 4'b0000);
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 8; s++) tick_and_check(s, (f == 0 && s == 0), 16'h8888);

    // Blink on the second instance
    @(negedge clk);
    digits_in = 16'h1234;
    blink_b   = 4'b0001;
    load_b    = 1'b1;
    @(posedge clk);
    #1;
    load_b = 1'b0;
    set_exp(7'h79, 7'h24, 7'h30, 7'h19, 4'b0000, 4'b0000);
    for (int t = 0; t < 16; t++) begin
      logic [3:0] ea;
      logic [6:0] es;
      int d;
      d = t % 4;
      @(negedge clk);
      en_b = 1'b1;
      @(posedge clk);
      #1;
      en_b = 1'b0;
      if (d == 0 && ((t / 4) % 2 == 1)) begin
        ea = 4'hF;
        es = 7'h7F;
      end else begin
        ea = exp_an[d];
        es = exp_seg[d];
      end
      $display("blink tick=%0d an_n=%b seg_n=%h", t, an_n_b, seg_n_b);
      check_eq($sformatf("blink%0d_an", t), 32'(an_n_b), 32'(ea));
      check_eq($sformatf("blink%0d_seg", t), 32'(seg_n_b), 32'(es));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
